wb_trace_buffer: RTL and testbench

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

---
 rtl/wb_trace_buffer.sv | 108 ++++++++++
 tb/tb_wb_trace_buffer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// Retired-instruction trace FIFO with a registered first-word-fall-through head.
// Defining WB_TRACE_TIMESTAMP_EN adds a per-entry cycle stamp presented on out_ts.
module wb_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_en,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [DATA_W-1:0]        in_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [DATA_W-1:0]        out_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [15:0]              drop_cnt
`ifdef WB_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]              out_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int EW = 2 * DATA_W + 32;
`else
  localparam int EW = 2 * DATA_W;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   level_reg, level_next;
  logic [EW-1:0] head_reg, head_next, in_entry;
  logic          out_valid_reg, full_reg;
  logic [15:0]   drop_cnt_reg;
  logic          push, pop, is_full, overflow, do_write;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] ts_reg;
  assign in_entry = {ts_reg, in_result, in_wdata};
  assign out_ts   = head_reg[EW-1 -: 32];

  always_ff @(posedge clk) begin
    if (!rst) ts_reg <= '0;
    else      ts_reg <= ts_reg + 32'd1;
  end
`else
  assign in_entry = {in_result, in_wdata};
`endif

  always_comb begin
    push        = cap_en && in_valid;
    pop         = out_valid_reg && out_ready;
    is_full     = (level_reg == (AW+1)'(DEPTH));
    overflow    = push && is_full && !pop;
    do_write    = push && !(overflow && MODE == 0);
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    level_next  = level_reg;
    head_next   = head_reg;
    // In wrap mode an overflowing write lands on the oldest slot, so the read side skips it.
    if (pop || (overflow && MODE != 0)) rd_ptr_next = rd_ptr_reg + AW'(1);
    if (do_write)                       wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop && !push)                   level_next = level_reg - (AW+1)'(1);
    else if (push && !pop && !is_full)  level_next = level_reg + (AW+1)'(1);
    // The new head is either an older stored entry or the word being written right now.
    if (level_next != '0) begin
      if (do_write && rd_ptr_next == wr_ptr_reg) head_next = in_entry;
      else                                       head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && rst) mem[wr_ptr_reg] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      level_reg     <= '0;
      head_reg      <= '0;
      out_valid_reg <= 1'b0;
      full_reg      <= 1'b0;
      drop_cnt_reg  <= '0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      level_reg     <= level_next;
      head_reg      <= head_next;
      out_valid_reg <= (level_next != '0);
      full_reg      <= (level_next == (AW+1)'(DEPTH));
      if (overflow && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = head_reg[2*DATA_W-1:DATA_W];
  assign out_wdata  = head_reg[DATA_W-1:0];
  assign level      = level_reg;
  assign full       = full_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: drives a stop-mode and a wrap-mode instance in lockstep
// against a queue scoreboard, with a phase table and hand-written reset/timestamp sequences.
module tb_wb_trace_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NPH   = 10;

  typedef struct {
    logic [31:0] r;
    logic [31:0] w;
    logic [31:0] ts;
  } ent_t;

  typedef struct {
    bit          rst_first;
    int          n;
    bit          cap;
    bit          vld;
    bit          rdy;
    logic [31:0] set_seq;
    int          lvl0;
    int          lvl1;
    int          drop0;
    int          drop1;
  } phase_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cap_en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_result = '0, in_wdata = '0;
  logic        ov [2];
  logic        fl [2];
  logic [31:0] orr [2];
  logic [31:0] ow [2];
  logic [4:0]  lv [2];
  logic [15:0] dc [2];
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] ots [2];
`endif

  ent_t        q [2][$];
  int          dropm [2];
  ent_t        last [2];
  logic [31:0] ts_m = '0;
  logic [31:0] seq = 32'd1;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  phase_t      ph [NPH];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      wb_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(gi)) u_dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .in_valid(in_valid),
        .in_result(in_result), .in_wdata(in_wdata),
        .out_valid(ov[gi]), .out_ready(out_ready),
        .out_result(orr[gi]), .out_wdata(ow[gi]),
        .level(lv[gi]), .full(fl[gi]), .drop_cnt(dc[gi])
`ifdef WB_TRACE_TIMESTAMP_EN
        , .out_ts(ots[gi])
`endif
      );
    end
  endgenerate

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s mode%0d got %h expected %h (t=%0t)", name, m, act, exp, $time);
  endtask

  task automatic check_all();
    ent_t h;
    for (int m = 0; m < 2; m++) begin
      if (q[m].size() > 0) begin
        h = q[m][0];
        last[m] = h;
      end else begin
        h = last[m];
      end
      chk("level", m, 32'(lv[m]), 32'(q[m].size()));
      chk("full", m, 32'(fl[m]), 32'(q[m].size() == DEPTH));
      chk("out_valid", m, 32'(ov[m]), 32'(q[m].size() > 0));
      chk("drop_cnt", m, 32'(dc[m]), 32'(dropm[m]));
      chk("out_result", m, orr[m], h.r);
      chk("out_wdata", m, ow[m], h.w);
`ifdef WB_TRACE_TIMESTAMP_EN
      chk("out_ts", m, ots[m], h.ts);
`endif
    end
  endtask

  task automatic step(input bit c, input bit v, input bit rdy);
    ent_t e, tmp;
    bit   push;
    bit   pop [2];
    cap_en = c; in_valid = v; out_ready = rdy;
    in_result = seq; in_wdata = seq + 32'hA0;
    e.r = seq; e.w = seq + 32'hA0; e.ts = ts_m;
    push = c && v;
    for (int m = 0; m < 2; m++) pop[m] = (q[m].size() > 0) && rdy;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (pop[m]) tmp = q[m].pop_front();
      if (push) begin
        if (q[m].size() < DEPTH) q[m].push_back(e);
        else begin
          if (m == 1) begin
            tmp = q[m].pop_front();
            q[m].push_back(e);
          end
          if (dropm[m] < 65535) dropm[m]++;
        end
      end
    end
    ts_m = ts_m + 32'd1;
    if (v) seq = seq + 32'd1;
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; cap_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      q[m].delete();
      dropm[m] = 0;
      last[m] = '{r: '0, w: '0, ts: '0};
    end
    ts_m = '0;
    #1;
    check_all();
    rst = 1'b1;
  endtask

  initial begin
    ph[0] = '{1, 5,  1, 1, 1, 32'h0,  1,  1,  0, 0};  // basic streaming 1..5
    ph[1] = '{0, 1,  1, 0, 1, 32'h0,  0,  0,  0, 0};
    ph[2] = '{0, 3,  1, 0, 1, 32'h0,  0,  0,  0, 0};  // out_ready while empty
    ph[3] = '{1, 20, 1, 1, 0, 32'h0,  16, 16, 4, 4};  // overflow by 4
    ph[4] = '{0, 1,  1, 1, 1, 32'h99, 16, 16, 4, 4};  // push+pop while full
    ph[5] = '{0, 3,  0, 1, 0, 32'h0,  16, 16, 4, 4};  // capture disabled
    ph[6] = '{0, 16, 0, 0, 1, 32'h0,  0,  0,  4, 4};  // drain, 0x99 last
    ph[7] = '{0, 10, 1, 1, 0, 32'h0,  10, 10, 4, 4};
    ph[8] = '{0, 3,  1, 1, 1, 32'h0,  10, 10, 4, 4};
    ph[9] = '{0, 10, 1, 0, 1, 32'h0,  0,  0,  4, 4};

    do_reset(2);

    for (int p = 0; p < NPH; p++) begin
      if (ph[p].rst_first) begin
        do_reset(1);
        seq = 32'd1;
      end
      if (ph[p].set_seq != 0) seq = ph[p].set_seq;
      for (int i = 0; i < ph[p].n; i++) step(ph[p].cap, ph[p].vld, ph[p].rdy);
      chk($sformatf("ph%0d_level", p), 0, 32'(lv[0]), 32'(ph[p].lvl0));
      chk($sformatf("ph%0d_level", p), 1, 32'(lv[1]), 32'(ph[p].lvl1));
      chk($sformatf("ph%0d_drop", p), 0, 32'(dc[0]), 32'(ph[p].drop0));
      chk($sformatf("ph%0d_drop", p), 1, 32'(dc[1]), 32'(ph[p].drop1));
    end

    // Reset in the middle of traffic empties the buffer; the next edge pushes again.
    seq = 32'h500;
    repeat (3) step(1, 1, 0);
    do_reset(1);
    step(1, 1, 0);
    for (int m = 0; m < 2; m++) begin
      chk("post_rst_level", m, 32'(lv[m]), 32'd1);
      chk("post_rst_result", m, orr[m], 32'h503);
    end

`ifdef WB_TRACE_TIMESTAMP_EN
    do_reset(1);
    for (int i = 0; i < 9; i++) step(1, (i == 3) || (i == 7), 0);
    for (int m = 0; m < 2; m++) chk("ts_first", m, ots[m], 32'd3);
    step(0, 0, 1);
    for (int m = 0; m < 2; m++) chk("ts_second", m, ots[m], 32'd7);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
